// File: rtl/pid_pkg.sv
// Shared definitions for the first-order plant model: default widths, FSM
// states, the 16-bit clamp helper and the LFSR constants used by the optional
// noise source.
package pid_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int DELAY_MAX_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      MULT,
      UPDATE,
      DONE
   } state_e;

   // Fibonacci LFSR: taps 16,14,13,11 map to state bits 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Clamp a wide signed value into the unsigned 16-bit range 0..16'hFFFF.
   function automatic logic [15:0] sat16(input logic signed [32:0] v);
      if (v < 0)
         return 16'h0000;
      else if (v > 33'sh0FFFF)
         return 16'hFFFF;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/plant_delay_line.sv
// Transport dead-time for the plant: circular sample buffer, write pointer,
// saturating fill counter and the delayed-sample read mux.
module plant_delay_line #(
   parameter int DATA_W    = 16,
   parameter int DELAY_MAX = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [DATA_W-1:0]            din_i,
   input  logic [$clog2(DELAY_MAX)-1:0] dead_time_i,
   output logic [DATA_W-1:0]            dout_o
);

   localparam int PTR_W = $clog2(DELAY_MAX);
   localparam logic [PTR_W:0] FILL_MAX = (PTR_W+1)'(DELAY_MAX);

   logic [DATA_W-1:0] mem_q [DELAY_MAX];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W:0]    fill_q;
   logic [PTR_W-1:0]  rd_ptr;

   // Read the sample pushed dead_time pushes ago; zero until that many exist.
   // NOTE: every output of an always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      rd_ptr = wr_ptr_q - dead_time_i;
      if (dead_time_i == '0)
         dout_o = din_i;
      else if (fill_q < {1'b0, dead_time_i})
         dout_o = '0;
      else
         dout_o = mem_q[rd_ptr];
   end

   // Sample storage.
   // NOTE: the buffer array has no reset; the fill counter masks stale entries, so clearing it would only cost logic.
   always_ff @(posedge clk) begin
      if (push_i)
         mem_q[wr_ptr_q] <= din_i;
   end

   // Write pointer wraps naturally; fill counts pushes up to the buffer depth.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else if (push_i) begin
         wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fill_q != FILL_MAX)
            fill_q <= fill_q + 1'b1;
      end
   end

endmodule

// File: rtl/pid_plant_model.sv
// First-order plant with static gain, power-of-two time constant and sample
// dead-time, closing the loop around a PID controller.
// Optional feature macro: PLANT_NOISE_EN adds bounded LFSR noise to feedback
// (internal state y stays noiseless).
module pid_plant_model
   import pid_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DELAY_MAX = DELAY_MAX_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_W-1:0]            control_signal,
   input  logic                         ctrl_valid,
   input  logic [DATA_W-1:0]            plant_gain,
   input  logic [3:0]                   tau_shift,
   input  logic [$clog2(DELAY_MAX)-1:0] dead_time,
   output logic [DATA_W-1:0]            feedback,
   output logic                         fb_valid,
   output logic                         busy,
   output logic                         sat,
   output logic                         overrun
);

   state_e state_q, state_d;

   logic [DATA_W-1:0]   u_q, ud_q, target_q, y_q, feedback_q;
   logic                sat_q, overrun_q;
   logic [DATA_W-1:0]   delay_out;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   target_next, y_next, fb_next;
   logic                gain_clip;
   logic signed [DATA_W:0] diff, step;

   plant_delay_line #(
      .DATA_W    (DATA_W),
      .DELAY_MAX (DELAY_MAX)
   ) u_delay (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (state_q == DELAY),
      .din_i       (u_q),
      .dead_time_i (dead_time),
      .dout_o      (delay_out)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Fixed five-state sequence; only IDLE waits for a strobe.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ctrl_valid) state_d = DELAY;
         DELAY:   state_d = MULT;
         MULT:    state_d = UPDATE;
         UPDATE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Gain multiply with Q8.8 rescale and the first-order step toward target.
   always_comb begin
      prod        = ud_q * plant_gain;
      target_next = sat16($signed({1'b0, prod >> 8}));
      gain_clip   = |prod[2*DATA_W-1:DATA_W+8];
      diff        = $signed({1'b0, target_q}) - $signed({1'b0, y_q});
      step        = diff >>> tau_shift;
      y_next      = DATA_W'($signed({1'b0, y_q}) + step);
   end

`ifdef PLANT_NOISE_EN
   logic [15:0]       lfsr_q;
   logic signed [4:0] noise;

   // Noise source advances once per completed update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr_q <= LFSR_SEED;
      else if (state_q == DONE)
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // Feedback is y plus a -8..+7 offset, clamped to the output range.
   always_comb begin
      noise   = $signed({1'b0, lfsr_q[3:0]}) - 5'sd8;
      fb_next = sat16($signed({{(DATA_W+1){1'b0}}, y_next}) + 33'(noise));
   end
`else
   // Noiseless build: feedback tracks y exactly.
   always_comb fb_next = y_next;
`endif

   // Datapath registers and sticky flags, each loaded in the state that owns it.
   // feedback loads together with y so it is already valid while fb_valid is high in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_q        <= '0;
         ud_q       <= '0;
         target_q   <= '0;
         y_q        <= '0;
         feedback_q <= '0;
         sat_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (ctrl_valid && state_q != IDLE)
            overrun_q <= 1'b1;
         case (state_q)
            IDLE:    if (ctrl_valid) u_q <= control_signal;
            DELAY:   ud_q <= delay_out;
            MULT: begin
               target_q <= target_next;
               if (gain_clip)
                  sat_q <= 1'b1;
            end
            UPDATE: begin
               y_q        <= y_next;
               feedback_q <= fb_next;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state_q != IDLE);
   assign fb_valid = (state_q == DONE);
   assign feedback = feedback_q;
   assign sat      = sat_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_pid_plant_model.sv
// Self-checking bench for pid_plant_model: a reference plant model pushes the
// expected feedback into a scoreboard when each sample is driven, and the value
// is popped and compared when fb_valid appears.
module tb_pid_plant_model;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] control_signal = '0;
   logic        ctrl_valid = 1'b0;
   logic [15:0] plant_gain = 16'h0100;
   logic [3:0]  tau_shift = '0;
   logic [3:0]  dead_time = '0;
   logic [15:0] feedback;
   logic        fb_valid, busy, sat, overrun;

   int checks = 0;
   int errors = 0;

   // reference model state
   int my = 0;
   int msat = 0;
   int movr = 0;
   int hist[$];
   int sb[$];

   pid_plant_model dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .control_signal (control_signal),
      .ctrl_valid     (ctrl_valid),
      .plant_gain     (plant_gain),
      .tau_shift      (tau_shift),
      .dead_time      (dead_time),
      .feedback       (feedback),
      .fb_valid       (fb_valid),
      .busy           (busy),
      .sat            (sat),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      my = 0; msat = 0; movr = 0;
      hist.delete();
      sb.delete();
   endtask

   // Expected plant response to one accepted sample.
   task automatic model_step(input int u);
      longint t;
      int ud, diff, dt;
      dt = int'(dead_time);
      if (dt == 0)
         ud = u;
      else if (hist.size() >= dt)
         ud = hist[hist.size() - dt];
      else
         ud = 0;
      hist.push_back(u);
      t = (longint'(ud) * longint'(plant_gain)) >>> 8;
      if (t > 65535) begin
         t = 65535;
         msat = 1;
      end
      diff = int'(t) - my;
      my = my + (diff >>> int'(tau_shift));
      sb.push_back(my);
   endtask

   task automatic cfg(input int k, input int tau, input int dt);
      plant_gain = 16'(k);
      tau_shift  = 4'(tau);
      dead_time  = 4'(dt);
   endtask

   task automatic compare_fb(input string name, input int exp);
      int lo, hi;
      checks++;
`ifdef PLANT_NOISE_EN
      lo = (exp - 8 < 0) ? 0 : exp - 8;
      hi = (exp + 7 > 65535) ? 65535 : exp + 7;
      if (int'(feedback) < lo || int'(feedback) > hi) begin
         errors++;
         $display("FAIL %s: feedback=%0d required %0d..%0d", name, feedback, lo, hi);
      end
`else
      lo = 0; hi = 0;
      if (int'(feedback) !== exp) begin
         errors++;
         $display("FAIL %s: feedback=%0d required %0d", name, feedback, exp);
      end
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ctrl_valid = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Drive one strobe, wait (bounded) for fb_valid, check latency, value and flags.
   task automatic send(input string name, input int u);
      int lat;
      int exp;
      model_step(u);
      @(negedge clk);
      control_signal = 16'(u);
      ctrl_valid = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (i == 1) ctrl_valid = 1'b0;
         if (fb_valid) lat = i;
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required 4", name, lat);
      end
      exp = sb.pop_front();
      if (lat != 0) compare_fb(name, exp);
      @(negedge clk);
      checks++;
      if (fb_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse: fb_valid=%0b busy=%0b after DONE, required 0 0", name, fb_valid, busy);
      end
      checks++;
      if (int'(sat) !== msat || int'(overrun) !== movr) begin
         errors++;
         $display("FAIL %s flags: sat=%0b overrun=%0b required %0d %0d", name, sat, overrun, msat, movr);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (feedback !== 16'h0 || fb_valid !== 1'b0 || busy !== 1'b0 || sat !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: fb=%0d v=%0b b=%0b s=%0b o=%0b required all 0",
                  feedback, fb_valid, busy, sat, overrun);
      end
      cfg(16'h0100, 0, 0);
      send("rst_pre1", 500);
      cfg(16'h0100, 0, 1);
      send("rst_pre2", 600);
      // abort a sample while the FSM sits in DELAY
      @(negedge clk);
      control_signal = 16'd700;
      ctrl_valid = 1'b1;
      @(negedge clk);
      ctrl_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (feedback !== 16'h0 || fb_valid !== 1'b0 || busy !== 1'b0 || sat !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_delay: fb=%0d v=%0b b=%0b s=%0b o=%0b required all 0",
                  feedback, fb_valid, busy, sat, overrun);
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // fill restarted at zero: dead_time=1 yields u_d=0
      send("rst_fill_zero", 800);
   endtask

   task automatic test_unity();
      do_reset();
      cfg(16'h0100, 0, 0);
      send("unity_1000", 1000);
   endtask

   task automatic test_tau();
      do_reset();
      cfg(16'h0100, 1, 0);
      for (int i = 0; i < 4; i++) send("tau1_step", 1000);
      cfg(16'h0100, 2, 0);
      send("tau2_down", 0);
   endtask

   task automatic test_dead_time();
      do_reset();
      cfg(16'h0100, 0, 2);
      for (int i = 0; i < 20; i++) send("dt2_wrap", 100 * (i + 1));
      cfg(16'h0100, 0, 15);
      for (int i = 0; i < 3; i++) send("dt15", 7 + i);
   endtask

   task automatic test_saturation();
      do_reset();
      cfg(16'h0200, 0, 0);
      send("sat_clip", 40000);
      send("sat_sticky", 10);
   endtask

   task automatic test_overrun();
      int pulses, lat, exp;
      do_reset();
      cfg(16'h0100, 1, 0);
      model_step(1234);
      @(negedge clk);
      control_signal = 16'd1234;
      ctrl_valid = 1'b1;
      pulses = 0; lat = 0; exp = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) ctrl_valid = 1'b0;
         if (i == 2) begin control_signal = 16'd4321; ctrl_valid = 1'b1; end
         if (i == 3) ctrl_valid = 1'b0;
         if (fb_valid) begin
            pulses++;
            if (lat == 0) begin
               lat = i;
               exp = sb.pop_front();
               compare_fb("ovr_value", exp);
            end
         end
      end
      checks++;
      if (pulses !== 1 || lat !== 4) begin
         errors++;
         $display("FAIL ovr_pulses: pulses=%0d latency=%0d required 1 and 4", pulses, lat);
      end
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_flag: overrun=%0b required 1", overrun);
      end
      movr = 1;
      send("ovr_after", 1234);
   endtask

   initial begin
      test_reset();
      test_unity();
      test_tau();
      test_dead_time();
      test_saturation();
      test_overrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
